// File: rtl/ysyx_pkg.sv
// Shared LSU definitions: store size codes, store-queue drain states and entry layout.
package ysyx_pkg;

    localparam int unsigned YSYX_XLEN  = 32;
    localparam int unsigned YSYX_ALU_W = 5;

    localparam logic [YSYX_ALU_W-1:0] YSYX_WSTRB_SB = 5'd1;
    localparam logic [YSYX_ALU_W-1:0] YSYX_WSTRB_SH = 5'd2;
    localparam logic [YSYX_ALU_W-1:0] YSYX_WSTRB_SW = 5'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } sq_state_t;

    typedef struct packed {
        logic [YSYX_XLEN-1:0] waddr;
        logic [YSYX_XLEN-1:0] wdata;
        logic [3:0]           wstrb;
        logic [YSYX_XLEN-1:0] pc;
    } sq_entry_t;

endpackage

// File: rtl/ysyx_lsu_sq_if.sv
// Store-queue boundary: commit port, load-conflict probe and data-memory write port.
interface ysyx_lsu_sq_if #(
    parameter int unsigned XLEN = 32
);
    logic            cm_valid;
    logic            cm_store;
    logic [4:0]      cm_alu;
    logic [XLEN-1:0] cm_waddr;
    logic [XLEN-1:0] cm_wdata;
    logic [XLEN-1:0] cm_pc;
    logic            sq_ready;
    logic            sq_empty;
    logic [XLEN-1:0] ld_addr;
    logic            ld_conflict;
    logic            mem_awvalid;
    logic            mem_awready;
    logic [XLEN-1:0] mem_awaddr;
    logic [XLEN-1:0] mem_wdata;
    logic [3:0]      mem_wstrb;
    logic            mem_bvalid;
    logic            mem_bready;

    modport slave (
        input  cm_valid, cm_store, cm_alu, cm_waddr, cm_wdata, cm_pc, ld_addr,
        input  mem_awready, mem_bvalid,
        output sq_ready, sq_empty, ld_conflict,
        output mem_awvalid, mem_awaddr, mem_wdata, mem_wstrb, mem_bready
    );

    modport master (
        output cm_valid, cm_store, cm_alu, cm_waddr, cm_wdata, cm_pc, ld_addr,
        output mem_awready, mem_bvalid,
        input  sq_ready, sq_empty, ld_conflict,
        input  mem_awvalid, mem_awaddr, mem_wdata, mem_wstrb, mem_bready
    );
endinterface

// File: rtl/ysyx_sq_lane.sv
// Maps a store size code and byte offset onto shifted write data and byte strobes.
module ysyx_sq_lane
    import ysyx_pkg::*;
#(
    parameter int unsigned XLEN = YSYX_XLEN
) (
    input  logic [YSYX_ALU_W-1:0] alu_i,
    input  logic [1:0]            off_i,
    input  logic [XLEN-1:0]       data_i,
    output logic [XLEN-1:0]       wdata_o,
    output logic [3:0]            wstrb_o,
    output logic                  known_o
);

    always_comb begin
        wdata_o = data_i << {off_i, 3'b000};
        wstrb_o = 4'b0000;
        known_o = 1'b1;
        case (alu_i)
            YSYX_WSTRB_SB: wstrb_o = 4'b0001 << off_i;
            YSYX_WSTRB_SH: wstrb_o = 4'b0011 << off_i;
            YSYX_WSTRB_SW: wstrb_o = 4'b1111;
            default:       known_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/ysyx_lsu_sq.sv
// Post-commit store queue: buffers retired stores in order and drains them to data memory.
module ysyx_lsu_sq
    import ysyx_pkg::*;
#(
    parameter int unsigned SQ_SIZE = 4,
    parameter int unsigned XLEN    = YSYX_XLEN
) (
    input logic           clock,
    input logic           reset,
    ysyx_lsu_sq_if.slave  bus
);

    localparam int unsigned PTR_W = $clog2(SQ_SIZE);
    localparam int unsigned CNT_W = PTR_W + 1;

    sq_entry_t        entries_q [SQ_SIZE];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    sq_state_t        state_q, state_d;

    logic             sq_ready_c;
    logic             push;
    logic             pop;
    logic             awvalid;
    logic             bready;
    logic [XLEN-1:0]  lane_wdata;
    logic [3:0]       lane_wstrb;
    logic             lane_known;
    sq_entry_t        head_e;
    logic             unused_bits;

    ysyx_sq_lane #(.XLEN(XLEN)) u_lane (
        .alu_i   (bus.cm_alu),
        .off_i   (bus.cm_waddr[1:0]),
        .data_i  (bus.cm_wdata),
        .wdata_o (lane_wdata),
        .wstrb_o (lane_wstrb),
        .known_o (lane_known)
    );

    // Ready is a pure function of registered occupancy, so it never loops back through commit.
    assign sq_ready_c = count_q < CNT_W'(SQ_SIZE);
    assign push       = bus.cm_valid && bus.cm_store && sq_ready_c;

    always_comb begin
        state_d = state_q;
        awvalid = 1'b0;
        bready  = 1'b0;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (count_q != '0) state_d = REQ;
            end
            REQ: begin
                awvalid = 1'b1;
                if (bus.mem_awready) state_d = RESP;
            end
            RESP: begin
                bready = 1'b1;
                if (bus.mem_bvalid) begin
                    pop     = 1'b1;
                    state_d = (count_q > CNT_W'(1) || push) ? REQ : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        head_d  = pop  ? head_q + PTR_W'(1) : head_q;
        tail_d  = push ? tail_q + PTR_W'(1) : tail_q;
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            entries_q[tail_q] <= '{
                waddr: {bus.cm_waddr[XLEN-1:2], 2'b00},
                wdata: lane_wdata,
                wstrb: lane_wstrb,
                pc:    bus.cm_pc
            };
        end
    end

    a_known_size: assert property (@(posedge clock) disable iff (reset) push |-> lane_known);

    // Entries in [head, head+count) are live; this includes the one currently on the bus.
    always_comb begin
        logic [PTR_W-1:0] rel;
        rel             = '0;
        bus.ld_conflict = 1'b0;
        for (int unsigned i = 0; i < SQ_SIZE; i++) begin
            rel = PTR_W'(i) - head_q;
            if (({1'b0, rel} < count_q) &&
                (entries_q[i].waddr[XLEN-1:2] == bus.ld_addr[XLEN-1:2])) begin
                bus.ld_conflict = 1'b1;
            end
        end
    end

    assign head_e          = entries_q[head_q];
    assign bus.sq_ready    = sq_ready_c;
    assign bus.sq_empty    = (count_q == '0) && (state_q == IDLE);
    assign bus.mem_awvalid = awvalid;
    assign bus.mem_bready  = bready;
    assign bus.mem_awaddr  = awvalid ? head_e.waddr : '0;
    assign bus.mem_wdata   = awvalid ? head_e.wdata : '0;
    assign bus.mem_wstrb   = awvalid ? head_e.wstrb : '0;
    assign unused_bits     = ^{bus.ld_addr[1:0], head_e.pc};

endmodule

// File: tb/tb_ysyx_lsu_sq.sv
// Directed scenarios plus randomized traffic checked against a queue-level reference model.
module tb_ysyx_lsu_sq;
    import ysyx_pkg::*;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
    } ent_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    ysyx_lsu_sq_if #(.XLEN(32)) bus ();
    ysyx_lsu_sq #(.SQ_SIZE(4), .XLEN(32)) dut (.clock(clock), .reset(reset), .bus(bus));

    ent_t        mq[$];
    logic [31:0] seen[$];
    int          ph;      // 0: waiting, 1: request on bus, 2: awaiting response
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic ent_t mk(input logic [4:0] alu, input logic [31:0] addr, input logic [31:0] data);
        ent_t e;
        int   off;
        off = int'(addr[1:0]);
        e.a = {addr[31:2], 2'b00};
        e.d = data << (8 * off);
        if (alu == YSYX_WSTRB_SB)      e.s = 4'(1 << off);
        else if (alu == YSYX_WSTRB_SH) e.s = 4'(3 << off);
        else if (alu == YSYX_WSTRB_SW) e.s = 4'hf;
        else                           e.s = 4'h0;
        return e;
    endfunction

    task automatic check_model();
        logic hit;
        hit = 1'b0;
        foreach (mq[i]) if (mq[i].a[31:2] == bus.ld_addr[31:2]) hit = 1'b1;
        chk("sq_ready", 32'(bus.sq_ready), 32'(mq.size() < 4));
        chk("sq_empty", 32'(bus.sq_empty), 32'(mq.size() == 0));
        chk("awvalid", 32'(bus.mem_awvalid), 32'(ph == 1));
        chk("bready", 32'(bus.mem_bready), 32'(ph == 2));
        chk("awaddr", bus.mem_awaddr, (ph == 1) ? mq[0].a : 32'h0);
        chk("wdata", bus.mem_wdata, (ph == 1) ? mq[0].d : 32'h0);
        chk("wstrb", 32'(bus.mem_wstrb), (ph == 1) ? 32'(mq[0].s) : 32'h0);
        chk("ld_conflict", 32'(bus.ld_conflict), 32'(hit));
    endtask

    task automatic step(input logic cv, input logic cs, input logic [4:0] alu,
                        input logic [31:0] addr, input logic [31:0] data,
                        input logic [31:0] ld, input logic awr, input logic bv);
        bus.cm_valid    = cv;
        bus.cm_store    = cs;
        bus.cm_alu      = alu;
        bus.cm_waddr    = addr;
        bus.cm_wdata    = data;
        bus.cm_pc       = addr ^ 32'h5a5a_0000;
        bus.ld_addr     = ld;
        bus.mem_awready = awr;
        bus.mem_bvalid  = bv;
        #1;
        check_model();
    endtask

    task automatic adv();
        logic push, pop, rst;
        int   sz, np;
        sz   = mq.size();
        push = bus.cm_valid && bus.cm_store && (sz < 4);
        pop  = (ph == 2) && bus.mem_bvalid;
        rst  = reset;
        np   = ph;
        case (ph)
            0: if (sz > 0) np = 1;
            1: if (bus.mem_awready) begin
                np = 2;
                seen.push_back(bus.mem_wdata);
            end
            2: if (bus.mem_bvalid) np = (sz - 1 + int'(push) > 0) ? 1 : 0;
            default: np = 0;
        endcase
        if (pop) void'(mq.pop_front());
        if (push) mq.push_back(mk(bus.cm_alu, bus.cm_waddr, bus.cm_wdata));
        ph = np;
        if (rst) begin
            mq.delete();
            ph = 0;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input logic awr, input logic bv);
        step(1'b0, 1'b0, YSYX_WSTRB_SB, 32'h0, 32'h0, 32'h0, awr, bv);
    endtask

    task automatic drain();
        for (int n = 0; n < 40 && !(mq.size() == 0 && ph == 0); n++) begin
            idle(1'b1, ph == 2);
            adv();
        end
        idle(1'b0, 1'b0);
        chk("drain_done", 32'(bus.sq_empty), 32'h1);
    endtask

    initial begin
        logic [31:0] exp_order[5];
        logic [31:0] hold_a, hold_d;
        logic [3:0]  hold_s;
        logic [4:0]  alu;
        logic [31:0] addr, ld;
        int          k;

        // Reset and reset values
        bus.cm_valid = 1'b0; bus.cm_store = 1'b0; bus.cm_alu = '0;
        bus.cm_waddr = '0; bus.cm_wdata = '0; bus.cm_pc = '0; bus.ld_addr = '0;
        bus.mem_awready = 1'b0; bus.mem_bvalid = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        mq.delete();
        ph = 0;
        idle(1'b0, 1'b0);
        chk("rst_sq_ready", 32'(bus.sq_ready), 32'h1);
        chk("rst_sq_empty", 32'(bus.sq_empty), 32'h1);
        chk("rst_awvalid", 32'(bus.mem_awvalid), 32'h0);
        chk("rst_awaddr", bus.mem_awaddr, 32'h0);

        // Single SB to top byte lane
        step(1'b1, 1'b1, YSYX_WSTRB_SB, 32'h8000_0003, 32'h0000_00ab, 32'h0, 1'b0, 1'b0);
        adv();
        idle(1'b0, 1'b0);
        chk("sb_latency_idle", 32'(bus.mem_awvalid), 32'h0);
        adv();
        idle(1'b1, 1'b0);
        chk("sb_awaddr", bus.mem_awaddr, 32'h8000_0000);
        chk("sb_wdata", bus.mem_wdata, 32'hab00_0000);
        chk("sb_wstrb", 32'(bus.mem_wstrb), 32'h8);
        adv();
        idle(1'b0, 1'b1);
        chk("sb_empty_during_resp", 32'(bus.sq_empty), 32'h0);
        adv();
        idle(1'b0, 1'b0);
        chk("sb_empty_after_b", 32'(bus.sq_empty), 32'h1);

        // Fill, hold-off, full push/pop, wrap ordering
        seen.delete();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, YSYX_WSTRB_SW, 32'h8000_0100 + 32'(4 * i), 32'(8'h11 * (i + 1)), 32'h0, 1'b0, 1'b0);
            adv();
        end
        step(1'b1, 1'b1, YSYX_WSTRB_SW, 32'h8000_0200, 32'h99, 32'h0, 1'b0, 1'b0);
        chk("full_not_ready", 32'(bus.sq_ready), 32'h0);
        adv();
        idle(1'b1, 1'b0);
        adv();
        step(1'b1, 1'b1, YSYX_WSTRB_SW, 32'h8000_0110, 32'h55, 32'h0, 1'b0, 1'b1);
        chk("full_pop_not_ready", 32'(bus.sq_ready), 32'h0);
        adv();
        step(1'b1, 1'b1, YSYX_WSTRB_SW, 32'h8000_0110, 32'h55, 32'h0, 1'b0, 1'b0);
        chk("after_pop_ready", 32'(bus.sq_ready), 32'h1);
        adv();
        idle(1'b0, 1'b0);
        chk("refull_not_ready", 32'(bus.sq_ready), 32'h0);
        drain();
        exp_order = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55};
        chk("order_count", 32'(seen.size()), 32'd5);
        for (int i = 0; i < 5 && i < seen.size(); i++) chk("order_data", seen[i], exp_order[i]);

        // Stall stability on the request channel
        step(1'b1, 1'b1, YSYX_WSTRB_SW, 32'h8000_0010, 32'hcafe_f00d, 32'h0, 1'b0, 1'b0);
        adv();
        idle(1'b0, 1'b0);
        adv();
        idle(1'b0, 1'b0);
        hold_a = bus.mem_awaddr; hold_d = bus.mem_wdata; hold_s = bus.mem_wstrb;
        for (int i = 0; i < 5; i++) begin
            idle(1'b0, 1'b0);
            chk("stall_awvalid", 32'(bus.mem_awvalid), 32'h1);
            chk("stall_awaddr", bus.mem_awaddr, 32'h8000_0010);
            chk("stall_wdata", bus.mem_wdata, hold_d);
            chk("stall_wstrb", 32'(bus.mem_wstrb), 32'(hold_s));
            adv();
        end
        chk("stall_awaddr_first", hold_a, 32'h8000_0010);
        idle(1'b1, 1'b0);
        adv();
        idle(1'b0, 1'b0);
        chk("stall_to_resp", 32'(bus.mem_bready), 32'h1);
        drain();

        // Load conflict against buffered halfword
        step(1'b1, 1'b1, YSYX_WSTRB_SH, 32'h0000_0100, 32'h1234, 32'h0, 1'b0, 1'b0);
        chk("ld_same_cycle", 32'(bus.ld_conflict), 32'h0);
        adv();
        step(1'b0, 1'b0, YSYX_WSTRB_SB, 32'h0, 32'h0, 32'h0000_0102, 1'b0, 1'b0);
        chk("ld_hit", 32'(bus.ld_conflict), 32'h1);
        step(1'b0, 1'b0, YSYX_WSTRB_SB, 32'h0, 32'h0, 32'h0000_0104, 1'b0, 1'b0);
        chk("ld_miss", 32'(bus.ld_conflict), 32'h0);
        drain();
        step(1'b0, 1'b0, YSYX_WSTRB_SB, 32'h0, 32'h0, 32'h0000_0102, 1'b0, 1'b0);
        chk("ld_after_pop", 32'(bus.ld_conflict), 32'h0);

        // Reset while a response is outstanding
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, YSYX_WSTRB_SW, 32'h8000_0300 + 32'(4 * i), 32'h700 + 32'(i), 32'h0, 1'b0, 1'b0);
            adv();
        end
        for (int n = 0; n < 10 && ph != 2; n++) begin
            idle(1'b1, 1'b0);
            adv();
        end
        chk("rst_mid_in_resp", 32'(ph), 32'd2);
        reset = 1'b1;
        idle(1'b0, 1'b0);
        adv();
        reset = 1'b0;
        idle(1'b0, 1'b0);
        chk("rstmid_sq_ready", 32'(bus.sq_ready), 32'h1);
        chk("rstmid_sq_empty", 32'(bus.sq_empty), 32'h1);
        chk("rstmid_awvalid", 32'(bus.mem_awvalid), 32'h0);
        chk("rstmid_bready", 32'(bus.mem_bready), 32'h0);

        // Randomized traffic against the queue model
        for (int n = 0; n < 400; n++) begin
            k = int'($urandom_range(0, 2));
            alu = (k == 0) ? YSYX_WSTRB_SB : (k == 1) ? YSYX_WSTRB_SH : YSYX_WSTRB_SW;
            addr = 32'h8000_0000 + 32'($urandom_range(0, 7) << 2);
            if (k == 0) addr = addr + 32'($urandom_range(0, 3));
            if (k == 1) addr = addr + 32'($urandom_range(0, 1) << 1);
            ld = 32'h8000_0000 + 32'($urandom_range(0, 9) << 2) + 32'($urandom_range(0, 3));
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), alu, addr, $urandom,
                 ld, 1'($urandom_range(0, 1)), (ph == 2) && ($urandom_range(0, 1) == 1));
            adv();
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
